// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: funct3 encodings, FSM states, byte strobes.
// Also holds the store lane helpers and the misalignment predicate.
package mem_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_LO   = 4'b0011;
    localparam logic [3:0] STRB_HI   = 4'b1100;
    localparam logic [3:0] STRB_ALL  = 4'b1111;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_SB:   store_strb = 4'b0001 << a;
            F3_SH:   store_strb = a[1] ? STRB_HI : STRB_LO;
            default: store_strb = STRB_ALL;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        case (f3)
            F3_SB:   store_wdata = {4{rs2[7:0]}};
            F3_SH:   store_wdata = {2{rs2[15:0]}};
            default: store_wdata = rs2;
        endcase
    endfunction

    // Unknown store widths behave as SW, so they count as word accesses here too.
    function automatic logic misaligned(input logic is_load, input logic [2:0] f3, input logic [1:0] a);
        logic half;
        logic word;
        if (is_load) begin
            half = (f3 == F3_LH) || (f3 == F3_LHU);
            word = (f3 == F3_LW);
        end else begin
            half = (f3 == F3_SH);
            word = (f3 != F3_SB) && (f3 != F3_SH);
        end
        misaligned = (half && a[0]) || (word && (a != 2'b00));
    endfunction
endpackage

// File: rtl/mem_if.sv
// EX-side, data-bus and writeback signals of the memory stage; names are from the stage's point of view.
// slave = the stage itself, master = whatever drives EX and the bus.
interface mem_if;
    import mem_pkg::*;
    logic            i_valid;
    logic [XLEN-1:0] i_alu_out;
    logic [XLEN-1:0] i_rs2;
    logic [2:0]      i_funct3;
    logic            i_load;
    logic            i_store;
    logic            i_wb_en;
    logic [4:0]      i_rd;
    logic            o_stall;
    logic            o_bus_req;
    logic            o_bus_we;
    logic [XLEN-1:0] o_bus_addr;
    logic [XLEN-1:0] o_bus_wdata;
    logic [3:0]      o_bus_wstrb;
    logic            i_bus_ack;
    logic [XLEN-1:0] i_bus_rdata;
    logic            o_wb_valid;
    logic [4:0]      o_wb_rd;
    logic [XLEN-1:0] o_wb_data;
    logic            o_misalign;

    modport slave (
        input  i_valid, i_alu_out, i_rs2, i_funct3, i_load, i_store, i_wb_en, i_rd,
        input  i_bus_ack, i_bus_rdata,
        output o_stall, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
        output o_wb_valid, o_wb_rd, o_wb_data, o_misalign
    );
    modport master (
        output i_valid, i_alu_out, i_rs2, i_funct3, i_load, i_store, i_wb_en, i_rd,
        output i_bus_ack, i_bus_rdata,
        input  o_stall, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
        input  o_wb_valid, o_wb_rd, o_wb_data, o_misalign
    );
endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: picks the byte/halfword lane by address and sign/zero-extends it.
// Purely combinational; unknown funct3 returns the whole word.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata_i >> {addr_lo_i, 3'b000});
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results to writeback (1 cycle) or runs one req/ack bus access per load/store.
// Stalls EX for the whole access including the ack cycle. MEM_MISALIGN_TRAP_EN drops misaligned accesses.
module mem_stage
    import mem_pkg::*;
(
    input logic  i_clk,
    input logic  i_rst_n,
    mem_if.slave bus
);
    state_e          state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] wb_data_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [4:0]      wb_rd_q;
    logic            we_q;
    logic            req_q;
    logic            wb_valid_q;
    logic            misalign_q;
    logic [XLEN-1:0] load_data;
    logic            is_mem;
    logic            trap;

    assign is_mem = bus.i_load || bus.i_store;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && misaligned(bus.i_load, bus.i_funct3, bus.i_alu_out[1:0]);
`else
    assign trap = 1'b0;
`endif

    mem_load_align u_align (
        .rdata_i   (bus.i_bus_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= STRB_NONE;
            f3_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        if (trap) begin
                            misalign_q <= 1'b1;
                        end else if (is_mem) begin
                            state_q <= ST_ACCESS;
                            addr_q  <= bus.i_alu_out;
                            f3_q    <= bus.i_funct3;
                            rd_q    <= bus.i_rd;
                            we_q    <= bus.i_store;
                            req_q   <= 1'b1;
                            wstrb_q <= bus.i_store ? store_strb(bus.i_funct3, bus.i_alu_out[1:0]) : STRB_NONE;
                            wdata_q <= bus.i_store ? store_wdata(bus.i_funct3, bus.i_rs2) : '0;
                        end else if (bus.i_wb_en && (bus.i_rd != 5'd0)) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= bus.i_rd;
                            wb_data_q  <= bus.i_alu_out;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Address and write data stay put after ack; only the request qualifiers drop.
                    if (bus.i_bus_ack) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wstrb_q <= STRB_NONE;
                        if (!we_q && (rd_q != 5'd0)) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_data;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_stall     = (state_q == ST_ACCESS);
    assign bus.o_bus_req   = req_q;
    assign bus.o_bus_we    = we_q;
    assign bus.o_bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.o_bus_wdata = wdata_q;
    assign bus.o_bus_wstrb = wstrb_q;
    assign bus.o_wb_valid  = wb_valid_q;
    assign bus.o_wb_rd     = wb_rd_q;
    assign bus.o_wb_data   = wb_data_q;
    assign bus.o_misalign  = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random aligned loads, writebacks checked against a scoreboard.
// Compile with MEM_MISALIGN_TRAP_EN to cover the trapping variant.
module tb_mem_stage;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    mem_if bus();

    mem_stage dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   ack_cyc = 0;
    int   stall_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every writeback must match the oldest expectation, in the expected cycle.
    always @(negedge i_clk) begin
        if (bus.o_wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_rd", 32'(bus.o_wb_rd), 32'(mon_e.rd));
                chk("wb_data", bus.o_wb_data, mon_e.data);
                chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (8 * a));
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic wbe, input logic [4:0] rd);
        int n = 0;
        exp_t e;
        @(negedge i_clk);
        while (bus.o_stall !== 1'b0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) chk("stall_timeout", 32'd1, 32'd0);
        bus.i_load = ld; bus.i_store = st; bus.i_funct3 = f3; bus.i_alu_out = alu;
        bus.i_rs2 = rs2; bus.i_wb_en = wbe; bus.i_rd = rd; bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0; bus.i_load = 1'b0; bus.i_store = 1'b0;
        acc_cyc = cyc;
        if (!ld && !st && wbe && rd != 5'd0) begin
            e.rd = rd; e.data = alu; e.cyc = acc_cyc;
            sb.push_back(e);
        end
    endtask

    // Called right after acceptance: waits 'waits' request cycles, then acks with rdata.
    task automatic bus_access(input int waits, input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        stall_cnt = 0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge i_clk);
            if (bus.o_stall === 1'b1) stall_cnt++;
            if (i == 0) begin
                chk("bus_req", 32'(bus.o_bus_req), 32'd1);
                chk("bus_addr", bus.o_bus_addr, exp_addr);
                chk("bus_we", 32'(bus.o_bus_we), 32'(exp_we));
                if (exp_we) begin
                    chk("bus_wstrb", 32'(bus.o_bus_wstrb), 32'(exp_strb));
                    chk("bus_wdata", bus.o_bus_wdata, exp_wdata);
                end
            end
            if (i == waits) begin
                bus.i_bus_ack = 1'b1;
                bus.i_bus_rdata = rdata;
            end
            @(posedge i_clk);
            #1;
        end
        bus.i_bus_ack = 1'b0;
        ack_cyc = cyc;
    endtask

    task automatic push_load(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        if (rd != 5'd0) begin
            e.rd = rd; e.data = data; e.cyc = ack_cyc;
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [3:0]  strb;
        exp_t        e;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bus.i_valid = 0; bus.i_alu_out = 0; bus.i_rs2 = 0; bus.i_funct3 = 0; bus.i_load = 0;
        bus.i_store = 0; bus.i_wb_en = 0; bus.i_rd = 0; bus.i_bus_ack = 0; bus.i_bus_rdata = 0;

        // Reset values
        #12;
        chk("rst_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_req", 32'(bus.o_bus_req), 32'd0);
        chk("rst_we", 32'(bus.o_bus_we), 32'd0);
        chk("rst_addr", bus.o_bus_addr, 32'd0);
        chk("rst_wdata", bus.o_bus_wdata, 32'd0);
        chk("rst_wstrb", 32'(bus.o_bus_wstrb), 32'd0);
        chk("rst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(bus.o_wb_rd), 32'd0);
        chk("rst_wb_data", bus.o_wb_data, 32'd0);
        chk("rst_misalign", 32'(bus.o_misalign), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1. plain ALU result, then rd=0 and wb_en=0 variants that must not write back
        issue(0, 0, 3'b000, 32'h1234, 0, 1, 5'd5);
        @(negedge i_clk);
        chk("add_stall", 32'(bus.o_stall), 32'd0);
        issue(0, 0, 3'b000, 32'h5555, 0, 1, 5'd0);
        issue(0, 0, 3'b000, 32'h6666, 0, 0, 5'd7);
        @(negedge i_clk);
        chk("idle_wb_data", bus.o_wb_data, 32'd0);

        // 2. LB / LBU at 0x103 with three wait cycles
        issue(1, 0, 3'b000, 32'h103, 0, 1, 5'd6);
        bus_access(3, 32'h80FF_FFFF, 32'h100, 0, 4'h0, 0);
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);
        push_load(5'd6, 32'hFFFF_FF80);
        issue(1, 0, 3'b100, 32'h103, 0, 1, 5'd7);
        bus_access(3, 32'h80FF_FFFF, 32'h100, 0, 4'h0, 0);
        push_load(5'd7, 32'h0000_0080);
        @(negedge i_clk);
        chk("req_dropped", 32'(bus.o_bus_req), 32'd0);

        // 3. SH at 0x202 and SB over all lanes: no writeback
        issue(0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 0, 5'd9);
        bus_access(0, 0, 32'h200, 1, 4'b1100, 32'hBEEF_BEEF);
        for (int i = 0; i < 4; i++) begin
            strb = 4'b0001 << i;
            issue(0, 1, 3'b000, 32'h300 + 32'(i), 32'h0000_00A5, 0, 5'd3);
            bus_access(1, 0, 32'h300, 1, strb, 32'hA5A5_A5A5);
        end

        // 4. LW acked immediately, ADD held in EX during the ack cycle
        issue(1, 0, 3'b010, 32'h40, 0, 1, 5'd10);
        @(negedge i_clk);
        chk("lw_stall_ack", 32'(bus.o_stall), 32'd1);
        bus.i_bus_ack = 1'b1; bus.i_bus_rdata = 32'hCAFE_F00D;
        bus.i_alu_out = 32'h77; bus.i_wb_en = 1'b1; bus.i_rd = 5'd11; bus.i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_bus_ack = 1'b0;
        chk("lw_ack_latency", 32'(cyc - acc_cyc), 32'd1);
        e.rd = 5'd10; e.data = 32'hCAFE_F00D; e.cyc = cyc; sb.push_back(e);
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        e.rd = 5'd11; e.data = 32'h77; e.cyc = cyc; sb.push_back(e);
        @(negedge i_clk);

        // 5. reset in the middle of an access with ack asserted
        issue(1, 0, 3'b010, 32'h80, 0, 1, 5'd12);
        @(negedge i_clk);
        bus.i_bus_ack = 1'b1; bus.i_bus_rdata = 32'h1111_2222;
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bus.o_bus_req), 32'd0);
        chk("rst_mid_stall", 32'(bus.o_stall), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_bus_ack = 1'b0;
        @(negedge i_clk);
        chk("post_rst_req", 32'(bus.o_bus_req), 32'd0);
        chk("post_rst_stall", 32'(bus.o_stall), 32'd0);
        issue(0, 0, 3'b000, 32'h99, 0, 1, 5'd13);

        // 6. LW at 0x2
        issue(1, 0, 3'b010, 32'h2, 0, 1, 5'd14);
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge i_clk);
        chk("misalign_pulse", 32'(bus.o_misalign), 32'd1);
        chk("misalign_req", 32'(bus.o_bus_req), 32'd0);
        chk("misalign_stall", 32'(bus.o_stall), 32'd0);
        @(negedge i_clk);
        chk("misalign_end", 32'(bus.o_misalign), 32'd0);
`else
        bus_access(1, 32'h1122_3344, 32'h0, 0, 4'h0, 0);
        push_load(5'd14, 32'h1122_3344);
        @(negedge i_clk);
        chk("no_misalign", 32'(bus.o_misalign), 32'd0);
`endif

        // ack with no request outstanding
        @(negedge i_clk);
        bus.i_bus_ack = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("stray_ack_req", 32'(bus.o_bus_req), 32'd0);
        bus.i_bus_ack = 1'b0;

        // random aligned loads, rd may be 0
        for (int i = 0; i < 16; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            a = 32'h1000 + 32'($urandom_range(0, 255));
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            d = $urandom;
            rd = 5'($urandom_range(0, 31));
            issue(1, 0, f3, a, 0, 1, rd);
            bus_access(int'($urandom_range(0, 2)), d, {a[31:2], 2'b00}, 0, 4'h0, 0);
            push_load(rd, model_load(f3, a[1:0], d));
        end

        repeat (3) @(negedge i_clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
